spi_reg_bank: RTL and testbench

//  Command/register stage directly downstream of the SPI slave on the icestick.
//  - Consumes each word the slave receives, framed by the chip-select line.
//  - Decodes a two-frame command protocol: a command frame, then a data frame.
//  - Maintains a bank of NREG writable registers that drive board pins.
//  - Supplies the word the slave shifts out on MISO in the following frame.

---
 rtl/spi_reg_bank_pkg.sv | 17 +
 rtl/spi_reg_bank_sel_sync.sv | 35 +++
 rtl/spi_reg_bank.sv | 157 +++++++++++++++
 tb/tb_spi_reg_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_bank_pkg.sv
// Shared types and constants for the SPI command/register stage.
package spi_reg_bank_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWData = 2'd1,
    StRData = 2'd2
  } state_e;

  // Idle/link-check word; the bank uses its low WIDTH bits.
  localparam logic [7:0] SigDefault = 8'hA5;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/spi_reg_bank_sel_sync.sv
// Two-flop synchronizer for the raw SPI chip select with edge pulses.
module spi_reg_bank_sel_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sel_ni,
  output logic rise_o,
  output logic fall_o
);

  logic       meta_q, sync_q, prev_q;
  logic [2:0] vld_q;
  logic [2:0] vld_d;

  // Edges are qualified until prev_q holds a post-reset sample, so a select
  // already low at reset release does not look like a frame start.
  assign vld_d = {vld_q[1:0], 1'b1};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      vld_q  <= '0;
    end else begin
      meta_q <= sel_ni;
      sync_q <= meta_q;
      prev_q <= sync_q;
      vld_q  <= vld_d;
    end
  end

  assign rise_o = vld_q[2] & sync_q & ~prev_q;
  assign fall_o = vld_q[2] & ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Two-frame SPI command decoder driving a bank of writable registers.
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       ADDR_W  = 2,
  parameter int unsigned       TIMEOUT = 1000000,
  parameter logic [WIDTH-1:0]  SIG     = WIDTH'(SigDefault)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sel_ni,
  input  logic [WIDTH-1:0]             rx_word_i,
  output logic [WIDTH-1:0]             tx_word_o,
  output logic [(2**ADDR_W)*WIDTH-1:0] reg_out_o,
  output logic                         wr_pulse_o,
  output logic [ADDR_W-1:0]            wr_addr_o,
  output logic                         err_o
);

  localparam int unsigned      NREG     = 2 ** ADDR_W;
  localparam int unsigned      CntW     = cnt_width(TIMEOUT);
  localparam int unsigned      CmdWrBit = WIDTH - 1;
  localparam logic [CntW-1:0]  CntMax   = CntW'(TIMEOUT - 1);

  logic sel_rise, sel_fall, eof;
  logic in_frame_q, in_frame_d;

  state_e                       state_q, state_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [WIDTH-1:0]             tx_q, tx_d;
  logic                         err_q, err_d;
  logic                         wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [NREG-1:0][WIDTH-1:0]   regs_q, regs_d;
  logic                         reg_we;

  logic              cmd_wr;
  logic              cmd_bad;
  logic [ADDR_W-1:0] cmd_addr;

  spi_reg_bank_sel_sync u_sel_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sel_ni (sel_ni),
    .rise_o (sel_rise),
    .fall_o (sel_fall)
  );

  // A rise without a preceding fall belongs to a frame cut short by reset.
  always_comb begin
    in_frame_d = in_frame_q;
    if (sel_fall) begin
      in_frame_d = 1'b1;
    end else if (sel_rise) begin
      in_frame_d = 1'b0;
    end
  end

  assign eof = sel_rise & in_frame_q;

  assign cmd_wr   = rx_word_i[CmdWrBit];
  assign cmd_addr = rx_word_i[ADDR_W-1:0];
  assign cmd_bad  = |rx_word_i[WIDTH-2:ADDR_W];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    err_d      = err_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    cnt_d      = cnt_q;
    reg_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (eof) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else if (cmd_wr) begin
            state_d = StWData;
            addr_d  = cmd_addr;
          end else begin
            state_d = StRData;
            addr_d  = cmd_addr;
            tx_d    = regs_q[cmd_addr];
          end
        end
      end
      StWData, StRData: begin
        // eof takes priority over an expiry in the same cycle.
        if (eof) begin
          state_d = StIdle;
          tx_d    = SIG;
          cnt_d   = '0;
          if (state_q == StWData) begin
            reg_we     = 1'b1;
            wr_pulse_d = 1'b1;
            wr_addr_d  = addr_q;
          end
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          tx_d    = SIG;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = SIG;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (reg_we) begin
      regs_d[addr_q] = rx_word_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_frame_q <= 1'b0;
      state_q    <= StIdle;
      addr_q     <= '0;
      tx_q       <= SIG;
      err_q      <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      cnt_q      <= '0;
      regs_q     <= '0;
    end else begin
      in_frame_q <= in_frame_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      err_q      <= err_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      cnt_q      <= cnt_d;
      regs_q     <= regs_d;
    end
  end

  assign tx_word_o  = tx_q;
  assign reg_out_o  = regs_q;
  assign wr_pulse_o = wr_pulse_q;
  assign wr_addr_o  = wr_addr_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed vectors, corner sequences, random frames.
module tb_spi_reg_bank;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned NREG    = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    sel_n;
  logic [WIDTH-1:0]        rx_word;
  logic [WIDTH-1:0]        tx_word;
  logic [NREG*WIDTH-1:0]   reg_out;
  logic                    wr_pulse;
  logic [ADDR_W-1:0]       wr_addr;
  logic                    err;

  always #5 clk = ~clk;

  spi_reg_bank #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT),
    .SIG     (8'hA5)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sel_ni     (sel_n),
    .rx_word_i  (rx_word),
    .tx_word_o  (tx_word),
    .reg_out_o  (reg_out),
    .wr_pulse_o (wr_pulse),
    .wr_addr_o  (wr_addr),
    .err_o      (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Fall, settle, present word, rise; returns at the negedge after the eof update.
  task automatic send_frame(input logic [7:0] w);
    sel_n = 1'b0;
    tick(3);
    rx_word = w;
    sel_n   = 1'b1;
    tick(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic check_all(input string tag, input logic [7:0] tx, input logic e,
                           input logic p, input logic [1:0] wa, input logic [31:0] regs);
    check({tag, " tx"},      32'(tx_word),  32'(tx));
    check({tag, " err"},     32'(err),      32'(e));
    check({tag, " wr_pulse"}, 32'(wr_pulse), 32'(p));
    if (p) check({tag, " wr_addr"}, 32'(wr_addr), 32'(wa));
    check({tag, " reg_out"}, reg_out,       regs);
  endtask

  typedef struct {
    logic [7:0]  word;
    logic [7:0]  tx;
    logic        err;
    logic        pulse;
    logic [1:0]  waddr;
    logic [31:0] regs;
  } vec_t;

  vec_t vecs[7];

  // Reference model: pending-transaction bookkeeping in plain terms.
  logic [7:0] m_regs[NREG];
  int         m_mode;  // 0 none, 1 awaiting write data, 2 awaiting dummy
  int         m_addr;
  logic [7:0] m_tx;
  logic       m_err;
  logic       m_pulse;
  logic [1:0] m_waddr;

  function automatic logic [31:0] model_regs();
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < NREG; k++) r[k*8 +: 8] = m_regs[k];
    return r;
  endfunction

  task automatic model_frame(input logic [7:0] w);
    int unsigned v;
    v = w;
    m_pulse = 1'b0;
    if (m_mode == 0) begin
      if (((v / 4) % 32) != 0) begin
        m_err = 1'b1;
      end else if (v >= 128) begin
        m_mode = 1;
        m_addr = v % 4;
      end else begin
        m_mode = 2;
        m_addr = v % 4;
        m_tx   = m_regs[m_addr];
      end
    end else begin
      if (m_mode == 1) begin
        m_regs[m_addr] = w;
        m_pulse = 1'b1;
        m_waddr = 2'(m_addr);
      end
      m_mode = 0;
      m_tx   = 8'hA5;
    end
  endtask

  initial begin
    logic [7:0] w;

    vecs[0] = '{8'h82, 8'hA5, 1'b0, 1'b0, 2'd0, 32'h0000_0000};
    vecs[1] = '{8'h3C, 8'hA5, 1'b0, 1'b1, 2'd2, 32'h003C_0000};
    vecs[2] = '{8'h02, 8'h3C, 1'b0, 1'b0, 2'd2, 32'h003C_0000};
    vecs[3] = '{8'h00, 8'hA5, 1'b0, 1'b0, 2'd2, 32'h003C_0000};
    vecs[4] = '{8'h90, 8'hA5, 1'b1, 1'b0, 2'd2, 32'h003C_0000};
    vecs[5] = '{8'h81, 8'hA5, 1'b1, 1'b0, 2'd2, 32'h003C_0000};
    vecs[6] = '{8'h55, 8'hA5, 1'b1, 1'b1, 2'd1, 32'h003C_5500};

    rst_n   = 1'b0;
    sel_n   = 1'b1;
    rx_word = '0;
    tick(2);
    check("reset tx", 32'(tx_word), 32'h0000_00A5);
    check("reset reg_out", reg_out, 32'h0);
    check("reset err", 32'(err), 32'h0);
    check("reset wr_pulse", 32'(wr_pulse), 32'h0);
    check("reset wr_addr", 32'(wr_addr), 32'h0);
    rst_n = 1'b1;
    tick(4);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].word);
      check_all($sformatf("vec%0d", i), vecs[i].tx, vecs[i].err, vecs[i].pulse,
                vecs[i].waddr, vecs[i].regs);
      if (vecs[i].pulse) begin
        tick(1);
        check($sformatf("vec%0d pulse width", i), 32'(wr_pulse), 32'h0);
      end
    end

    // Timeout with no data frame.
    do_reset();
    send_frame(8'h83);
    tick(TIMEOUT - 1);
    check("to before expiry err", 32'(err), 32'h0);
    tick(1);
    check("to expiry err", 32'(err), 32'h1);
    check("to expiry tx", 32'(tx_word), 32'h0000_00A5);
    send_frame(8'h03);
    check_all("to read back", 8'h00, 1'b1, 1'b0, 2'd0, 32'h0);
    send_frame(8'h00);
    check_all("to dummy", 8'hA5, 1'b1, 1'b0, 2'd0, 32'h0);

    // eof landing on the expiry cycle completes the write.
    do_reset();
    send_frame(8'h83);
    sel_n = 1'b0;
    tick(TIMEOUT - 3);
    rx_word = 8'h77;
    sel_n   = 1'b1;
    tick(3);
    check_all("eof at expiry", 8'hA5, 1'b0, 1'b1, 2'd3, 32'h7700_0000);

    // One cycle later: timeout first, then 0x77 decodes as an invalid command.
    do_reset();
    send_frame(8'h83);
    sel_n = 1'b0;
    tick(TIMEOUT - 2);
    rx_word = 8'h77;
    sel_n   = 1'b1;
    tick(3);
    check_all("eof after expiry", 8'hA5, 1'b1, 1'b0, 2'd0, 32'h0);

    // Reset mid-frame: partial frame discarded, next frame is a command.
    do_reset();
    send_frame(8'h81);
    send_frame(8'h55);
    check("pre-reset reg_out", reg_out, 32'h0000_5500);
    send_frame(8'h80);
    sel_n = 1'b0;
    tick(3);
    rx_word = 8'h81;
    rst_n   = 1'b0;
    tick(2);
    check("mid reset reg_out", reg_out, 32'h0);
    rst_n = 1'b1;
    tick(5);
    sel_n = 1'b1;
    tick(4);
    check("partial rise wr_pulse", 32'(wr_pulse), 32'h0);
    check("partial rise tx", 32'(tx_word), 32'h0000_00A5);
    send_frame(8'h02);
    check_all("post-reset cmd", 8'h00, 1'b0, 1'b0, 2'd0, 32'h0);
    send_frame(8'h00);
    check_all("post-reset dummy", 8'hA5, 1'b0, 1'b0, 2'd0, 32'h0);

    // Random frames against the reference model.
    do_reset();
    for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
    m_mode  = 0;
    m_addr  = 0;
    m_tx    = 8'hA5;
    m_err   = 1'b0;
    m_pulse = 1'b0;
    m_waddr = 2'd0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       w = 8'h80 | 8'($urandom_range(0, 3));
        1:       w = 8'($urandom_range(0, 3));
        default: w = 8'($urandom);
      endcase
      send_frame(w);
      model_frame(w);
      check($sformatf("rnd%0d tx", i), 32'(tx_word), 32'(m_tx));
      check($sformatf("rnd%0d err", i), 32'(err), 32'(m_err));
      check($sformatf("rnd%0d wr_pulse", i), 32'(wr_pulse), 32'(m_pulse));
      check($sformatf("rnd%0d wr_addr", i), 32'(wr_addr), 32'(m_waddr));
      check($sformatf("rnd%0d reg_out", i), reg_out, model_regs());
      tick(int'($urandom_range(0, 8)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
